clip_record_controller: RTL
===========================

Name: clip_record_controller

Overview:
- Record/playback sequencer for the two-clip audio recorder.
- Sits directly upstream of the seven-segment LED interface and drives the sample memory.
- Turns record/play button presses and the clip-select switches into memory write/read strobes and addresses.
- Exports mode and active-clip status, which the LED interface consumes for display.

Parameters:
ADDR_W, 10, width of the per-clip sample offset; each clip holds up to 2**ADDR_W samples
CLIP_LEN, 1024, maximum samples per clip; must be at least 2 and at most 2**ADDR_W

Ports:
clock  input  1  system clock; all logic is on its rising edge
reset_n  input  1  asynchronous, active-low reset
record_btn  input  1  raw record button, asynchronous to clock
play_btn  input  1  raw play button, asynchronous to clock
switch0  input  1  record clip select (0 = clip 1, 1 = clip 2)
switch1  input  1  play clip select (0 = clip 1, 1 = clip 2)
sample_tick  input  1  one-cycle strobe at the audio sample rate
mem_addr  output  ADDR_W+1  {active_clip, offset}
mem_we  output  1  sample write strobe
mem_re  output  1  sample read strobe
mode  output  2  00 = idle, 01 = record, 10 = play; 11 is never driven
active_clip  output  1  clip currently latched for record or play
clip_valid  output  2  bit i set when clip i+1 holds at least one sample
done_pulse  output  1  one-cycle pulse when a record or play operation ends

Behaviour:
- Reset (asynchronous, reset_n=0) forces all outputs to 0:
  - state=IDLE, offset=0, clip_len[0..1]=0, clip_valid=00.
  - Synchronizer flops are cleared.
  - Reset mid-operation aborts the operation immediately. The stored clip is discarded (clip_valid=00).
- Button conditioning:
  - Each button passes through a 2-flop synchronizer plus a third delay flop.
  - The edge signal is s2 & ~s3.
  - mode changes at the 3rd rising clock edge after the first edge that samples the button high.
  - Holding a button produces exactly one edge.
- State IDLE:
  - Record edge: latch active_clip=switch0, set offset=0, clear clip_valid[switch0], go to RECORD.
  - Play edge with clip_valid[switch1]=1: latch active_clip=switch1, set offset=0, go to PLAY.
  - Play edge with clip_valid[switch1]=0: ignored, state stays IDLE.
  - Record and play edges in the same cycle: record wins.
- State RECORD:
  - mem_we = sample_tick & ~record_edge. This is combinational, in the same cycle as the tick.
  - mem_addr presents the current offset during the tick cycle.
  - Each write increments offset on the clock edge closing the tick cycle.
  - Write with offset==CLIP_LEN-1:
    - store clip_len=CLIP_LEN, set clip_valid, pulse done_pulse;
    - go to IDLE with offset=0.
  - Record edge (early stop):
    - store clip_len=offset;
    - set clip_valid only if offset>0;
    - pulse done_pulse, go to IDLE.
    - A tick in the same cycle as the stop is not written; stop wins.
  - Play edges are ignored.
- State PLAY:
  - mem_re = sample_tick & ~play_edge, with the same address timing as RECORD.
  - Read with offset==clip_len[active_clip]-1: pulse done_pulse, go to IDLE.
  - Play edge stops playback the same way; the tick in that cycle is suppressed.
  - Record edges are ignored.
- Switch changes outside IDLE are ignored, because the clip is latched at operation start.
- mem_addr is {active_clip, offset}. In IDLE, offset is 0.
- mem_we and mem_re are never both high. Neither is asserted in IDLE.
- clip_len registers are ADDR_W+1 bits wide, so they can hold CLIP_LEN.
- offset never wraps. It is returned to 0 on every transition into IDLE.

Decomposition:
- Shared package recorder_pkg holds:
  - state enum state_t {IDLE, RECORD, PLAY};
  - mode encoding constants MODE_IDLE=2'b00, MODE_REC=2'b01, MODE_PLAY=2'b10.
  - The LED interface imports the same constants.
- One sub-module, btn_edge_sync: 2-flop synchronizer, delay flop and rising-edge detect. It is instantiated twice, once per button.

Test Plan:
All scenarios use CLIP_LEN=8 and ADDR_W=3.
1. Reset:
   - Stimulus: assert reset_n=0 mid-RECORD.
   - Response: mode=00, mem_we=0, clip_valid=00 immediately; no done_pulse.
2. Full record:
   - Stimulus: switch0=1, record press, then 8 ticks.
   - Response: mem_we on exactly 8 ticks at mem_addr 8..15; done_pulse once; mode=00; clip_valid=10.
3. Early stop:
   - Stimulus: record clip 1, 3 ticks, then a record press coinciding with a tick.
   - Response: writes at addr 0..2 only; clip_len=3; clip_valid[0]=1.
4. Playback:
   - Stimulus: after scenario 3, switch1=0, play press, then 5 ticks.
   - Response: mem_re at addr 0,1,2 only; done_pulse after the 3rd read; mode=00.
5. Invalid play:
   - Stimulus: play press with switch1 selecting an empty clip.
   - Response: mode stays 00; no mem_re.
6. Priority and latency:
   - Stimulus: record and play pressed in the same cycle.
   - Response: mode=01 at the 3rd clock edge after sampling; a held button yields a single transition.

Source files
------------

// File: rtl/clip_record_controller_pkg.sv
// Shared definitions for the two-clip recorder: sequencer states and the mode
// encoding that the LED interface decodes for display.
package recorder_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      PLAY   = 2'd2
   } state_t;

   localparam logic [1:0] MODE_IDLE = 2'b00;
   localparam logic [1:0] MODE_REC  = 2'b01;
   localparam logic [1:0] MODE_PLAY = 2'b10;
endpackage

// File: rtl/clip_record_controller_if.sv
// Sample-memory strobe/address bus driven by the record/playback sequencer.
interface clip_record_controller_if #(parameter int ADDR_W = 10);
   logic [ADDR_W:0] mem_addr;
   logic            mem_we;
   logic            mem_re;

   modport master (output mem_addr, mem_we, mem_re);
   modport slave  (input  mem_addr, mem_we, mem_re);
endinterface

// File: rtl/clip_record_controller_btn_edge_sync.sv
// Brings a raw button into the clock domain and emits one pulse per press.
module btn_edge_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic btn,
   output logic rise
);
   // [0],[1] synchronize; [2] is the one-cycle delay used for edge detection
   logic [2:0] sync_pipe;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sync_pipe <= '0;
      else          sync_pipe <= {sync_pipe[1:0], btn};
   end

   assign rise = sync_pipe[1] & ~sync_pipe[2];
endmodule

// File: rtl/clip_record_controller.sv
// Record/playback sequencer: turns button presses and clip selects into
// sample-memory strobes/addresses and exports mode/clip status.
module clip_record_controller
   import recorder_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int CLIP_LEN = 1024
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            record_btn,
   input  logic                            play_btn,
   input  logic                            switch0,
   input  logic                            switch1,
   input  logic                            sample_tick,
   clip_record_controller_if.master        mem,
   output logic [1:0]                      mode,
   output logic                            active_clip,
   output logic [1:0]                      clip_valid,
   output logic                            done_pulse
);
   localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(CLIP_LEN - 1);
   localparam logic [ADDR_W:0]   FULL_LEN = (ADDR_W + 1)'(CLIP_LEN);
   localparam logic [ADDR_W:0]   ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state;
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W:0]   clip_len [0:1];
   logic [ADDR_W:0]   play_last;
   logic              rec_rise, play_rise;
   logic              wr, rd;

   btn_edge_sync u_rec_sync  (.clock(clock), .reset_n(reset_n), .btn(record_btn), .rise(rec_rise));
   btn_edge_sync u_play_sync (.clock(clock), .reset_n(reset_n), .btn(play_btn),   .rise(play_rise));

   // A stop press in the same cycle as a tick suppresses that tick
   assign wr = (state == RECORD) & sample_tick & ~rec_rise;
   assign rd = (state == PLAY)   & sample_tick & ~play_rise;

   assign mem.mem_we   = wr;
   assign mem.mem_re   = rd;
   assign mem.mem_addr = {active_clip, offset};

   // A clip is valid exactly when it holds a non-zero sample count
   assign clip_valid[0] = |clip_len[0];
   assign clip_valid[1] = |clip_len[1];
   assign play_last     = clip_len[active_clip] - ONE_LEN;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         mode        <= MODE_IDLE;
         offset      <= '0;
         active_clip <= 1'b0;
         clip_len[0] <= '0;
         clip_len[1] <= '0;
         done_pulse  <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (rec_rise) begin
                  active_clip       <= switch0;
                  offset            <= '0;
                  clip_len[switch0] <= '0;
                  state             <= RECORD;
                  mode              <= MODE_REC;
               end else if (play_rise && clip_valid[switch1]) begin
                  active_clip <= switch1;
                  offset      <= '0;
                  state       <= PLAY;
                  mode        <= MODE_PLAY;
               end
            end
            RECORD: begin
               if (rec_rise) begin
                  clip_len[active_clip] <= {1'b0, offset};
                  done_pulse            <= 1'b1;
                  offset                <= '0;
                  state                 <= IDLE;
                  mode                  <= MODE_IDLE;
               end else if (wr) begin
                  if (offset == LAST_OFF) begin
                     clip_len[active_clip] <= FULL_LEN;
                     done_pulse            <= 1'b1;
                     offset                <= '0;
                     state                 <= IDLE;
                     mode                  <= MODE_IDLE;
                  end else begin
                     offset <= offset + 1'b1;
                  end
               end
            end
            PLAY: begin
               if (play_rise || (rd && ({1'b0, offset} == play_last))) begin
                  done_pulse <= 1'b1;
                  offset     <= '0;
                  state      <= IDLE;
                  mode       <= MODE_IDLE;
               end else if (rd) begin
                  offset <= offset + 1'b1;
               end
            end
            default: begin
               offset <= '0;
               state  <= IDLE;
               mode   <= MODE_IDLE;
            end
         endcase
      end
   end
endmodule
